// File: rtl/mm_share_arbiter.sv
// mm_share_arbiter: two-requester arbiter sharing one systolic_matrix_mult engine.
//   clk, rst_n                   clock, asynchronous active-low reset
//   req[1:0] / gnt[1:0]          per-requester job request / one-hot engine owner
//   rq_a_* / rq_b_*              per-requester A and B element streams (slice i = requester i)
//   mm_start, mm_a_*, mm_b_*     start pulse and owner-muxed A/B streams to the engine
//   mm_c_*, mm_done              result stream and job completion from the engine
//   rs_c_data/row/col            registered result, broadcast to both requesters
//   rs_c_valid[1:0], rs_done[1:0] result-valid and job-done on the owner's bit only
//   busy                         high whenever a job is in progress
// Build option: define MM_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins ties)
// instead of round-robin.
module mm_share_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int M = 4,
  parameter int N = 2,
  parameter int K = 3,
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  input  logic [2*DATA_WIDTH-1:0] rq_a_data,
  input  logic [2*MW-1:0]         rq_a_row,
  input  logic [2*KW-1:0]         rq_a_col,
  input  logic [1:0]              rq_a_valid,
  input  logic [2*DATA_WIDTH-1:0] rq_b_data,
  input  logic [2*KW-1:0]         rq_b_row,
  input  logic [2*NW-1:0]         rq_b_col,
  input  logic [1:0]              rq_b_valid,
  output logic                    mm_start,
  output logic [DATA_WIDTH-1:0]   mm_a_data,
  output logic [MW-1:0]           mm_a_row,
  output logic [KW-1:0]           mm_a_col,
  output logic                    mm_a_valid,
  output logic [DATA_WIDTH-1:0]   mm_b_data,
  output logic [KW-1:0]           mm_b_row,
  output logic [NW-1:0]           mm_b_col,
  output logic                    mm_b_valid,
  input  logic [DATA_WIDTH-1:0]   mm_c_data,
  input  logic [MW-1:0]           mm_c_row,
  input  logic [NW-1:0]           mm_c_col,
  input  logic                    mm_c_valid,
  input  logic                    mm_done,
  output logic [DATA_WIDTH-1:0]   rs_c_data,
  output logic [MW-1:0]           rs_c_row,
  output logic [NW-1:0]           rs_c_col,
  output logic [1:0]              rs_c_valid,
  output logic [1:0]              rs_done,
  output logic                    busy
);
  localparam int CAW = $clog2(M*K+1);
  localparam int CBW = $clog2(K*N+1);
  typedef enum logic [1:0] {IDLE, START, LOAD, WAIT} state_e;
  state_e state_q, state_d;
  logic owner_q, owner_d, win;
  logic [CAW-1:0] a_cnt_q, a_cnt_d;
  logic [CBW-1:0] b_cnt_q, b_cnt_d;
  logic a_full, b_full;
  logic [DATA_WIDTH-1:0] rs_c_data_q;
  logic [MW-1:0] rs_c_row_q;
  logic [NW-1:0] rs_c_col_q;
  logic [1:0] rs_c_valid_q, rs_done_q;

`ifdef MM_ARB_FIXED_PRIORITY_EN
  assign win = ~req[0];
`else
  // last_q holds the previous winner; reset to 1 so requester 0 takes the first tie.
  logic last_q;
  assign win = (req == 2'b11) ? ~last_q : req[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (state_q == IDLE && |req) last_q <= win;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      rs_c_data_q  <= '0;
      rs_c_row_q   <= '0;
      rs_c_col_q   <= '0;
      rs_c_valid_q <= 2'b00;
      rs_done_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      rs_c_valid_q <= (state_q == WAIT && mm_c_valid) ? gnt : 2'b00;
      rs_done_q    <= (state_q == WAIT && mm_done) ? gnt : 2'b00;
      if (state_q == WAIT && mm_c_valid) begin
        rs_c_data_q <= mm_c_data;
        rs_c_row_q  <= mm_c_row;
        rs_c_col_q  <= mm_c_col;
      end
    end
  end

  // LOAD ends on the cycle the final outstanding beat is forwarded, so "full"
  // looks ahead by the beat being accepted this cycle.
  always_comb begin
    a_full  = (a_cnt_q == CAW'(M*K)) || (mm_a_valid && a_cnt_q == CAW'(M*K-1));
    b_full  = (b_cnt_q == CBW'(K*N)) || (mm_b_valid && b_cnt_q == CBW'(K*N-1));
    a_cnt_d = (state_q == LOAD) ? a_cnt_q + CAW'(mm_a_valid) : '0;
    b_cnt_d = (state_q == LOAD) ? b_cnt_q + CBW'(mm_b_valid) : '0;
    owner_d = (state_q == IDLE && |req) ? win : owner_q;
    state_d = (state_q == IDLE)  ? (|req ? START : IDLE) :
              (state_q == START) ? LOAD :
              (state_q == LOAD)  ? ((a_full && b_full) ? WAIT : LOAD) :
              (mm_done ? IDLE : WAIT);
  end

  always_comb begin
    busy       = state_q != IDLE;
    gnt        = busy ? {owner_q, ~owner_q} : 2'b00;
    mm_start   = state_q == START;
    mm_a_data  = owner_q ? rq_a_data[2*DATA_WIDTH-1:DATA_WIDTH] : rq_a_data[DATA_WIDTH-1:0];
    mm_a_row   = owner_q ? rq_a_row[2*MW-1:MW] : rq_a_row[MW-1:0];
    mm_a_col   = owner_q ? rq_a_col[2*KW-1:KW] : rq_a_col[KW-1:0];
    mm_a_valid = state_q == LOAD && rq_a_valid[owner_q] && a_cnt_q != CAW'(M*K);
    mm_b_data  = owner_q ? rq_b_data[2*DATA_WIDTH-1:DATA_WIDTH] : rq_b_data[DATA_WIDTH-1:0];
    mm_b_row   = owner_q ? rq_b_row[2*KW-1:KW] : rq_b_row[KW-1:0];
    mm_b_col   = owner_q ? rq_b_col[2*NW-1:NW] : rq_b_col[NW-1:0];
    mm_b_valid = state_q == LOAD && rq_b_valid[owner_q] && b_cnt_q != CBW'(K*N);
    rs_c_data  = rs_c_data_q;
    rs_c_row   = rs_c_row_q;
    rs_c_col   = rs_c_col_q;
    rs_c_valid = rs_c_valid_q;
    rs_done    = rs_done_q;
  end
endmodule
